// File: rtl/cpu_bus_responder_pkg.sv
// Shared widths, FSM encodings, request payload and window decode for the CPU bus responder.
// Imported by cpu_bus_responder and cpu_sync_ram.
package cpu_bus_responder_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] RESP_ST_IDLE   = 2'd0;
  localparam logic [1:0] RESP_ST_WAIT   = 2'd1;
  localparam logic [1:0] RESP_ST_ACCESS = 2'd2;
  localparam logic [1:0] RESP_ST_RESP   = 2'd3;

  // Request captured in IDLE and held for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              illegal;
  } bus_req_t;

  // True when every address bit above the RAM index matches the window base.
  function automatic logic win_hit(input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] base,
                                   input int unsigned       aw);
    logic [ADDR_W-1:0] diff;
    diff = (a ^ base) >> aw;
    return (diff == '0);
  endfunction

endpackage

// File: rtl/cpu_sync_ram.sv
// Single-port byte RAM with a registered read port and a write enable.
// Contents are deliberately not reset.
module cpu_sync_ram
  import cpu_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic [RAM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         q
);

  localparam int unsigned DEPTH = 1 << RAM_ADDR_WIDTH;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write and read share the address; a read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 65c816 bus: window decode, programmable wait states,
// on-chip RAM access and a one-cycle ready/bus_err completion pulse.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int unsigned       RAM_ADDR_WIDTH = 12,
  parameter logic [ADDR_W-1:0] RAM_BASE       = 24'h000000,
  parameter int unsigned       WAIT_STATES    = 1,
  parameter logic [DATA_W-1:0] OPEN_BUS_VAL   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              bus_err
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  bus_req_t          req;
  bus_req_t          req_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              ready_nxt;
  logic              err_nxt;

  logic              hit_c;
  logic              ram_we_c;
  logic              ram_re_c;
  logic [DATA_W-1:0] ram_q;

  assign hit_c = win_hit(req.addr, RAM_BASE, RAM_ADDR_WIDTH);

  cpu_sync_ram #(
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .addr  (req.addr[RAM_ADDR_WIDTH-1:0]),
    .wdata (req.data),
    .q     (ram_q)
  );

  // State, latched request, wait counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESP_ST_IDLE;
      req      <= '0;
      cnt      <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      req      <= req_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_nxt;
      ready    <= ready_nxt;
      bus_err  <= err_nxt;
    end
  end

  // Next-state, next-output and RAM strobe decode.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    ram_we_c  = 1'b0;
    ram_re_c  = 1'b0;

    case (state)
      RESP_ST_IDLE: begin
        if (enable && (re || we)) begin
          req_nxt.addr    = addr;
          req_nxt.data    = data_in;
          req_nxt.wr      = we;
          req_nxt.illegal = re && we;
          cnt_nxt         = CNT_W'(WAIT_STATES);
          state_nxt       = (WAIT_STATES != 0) ? RESP_ST_WAIT : RESP_ST_ACCESS;
        end
      end

      RESP_ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = RESP_ST_ACCESS;
        end
      end

      RESP_ST_ACCESS: begin
        if (hit_c && !req.illegal) begin
          ram_we_c = req.wr;
          ram_re_c = !req.wr;
        end
        state_nxt = RESP_ST_RESP;
      end

      RESP_ST_RESP: begin
        ready_nxt = 1'b1;
        err_nxt   = !hit_c || req.illegal;
        // Writes leave data_out alone; illegal requests count as open-bus reads.
        if (req.illegal || !req.wr) begin
          data_nxt = (hit_c && !req.illegal) ? ram_q : OPEN_BUS_VAL;
        end
        state_nxt = RESP_ST_IDLE;
      end

      default: begin
        state_nxt = RESP_ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder at WAIT_STATES 0, 1 and 15.
// Index 0 -> WAIT_STATES=0, index 1 -> WAIT_STATES=1, index 2 -> WAIT_STATES=15.
module tb_cpu_bus_responder;

  logic             clk;
  logic             rst;
  logic [2:0]       en_v;
  logic [2:0]       re_v;
  logic [2:0]       we_v;
  logic [2:0][23:0] addr_v;
  logic [2:0][7:0]  din_v;
  logic [2:0][7:0]  dout_v;
  logic [2:0]       rdy_v;
  logic [2:0]       err_v;

  int checks;
  int errors;

  cpu_bus_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .enable(en_v[0]), .re(re_v[0]), .we(we_v[0]),
    .addr(addr_v[0]), .data_in(din_v[0]), .data_out(dout_v[0]),
    .ready(rdy_v[0]), .bus_err(err_v[0])
  );

  cpu_bus_responder #(.WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .enable(en_v[1]), .re(re_v[1]), .we(we_v[1]),
    .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout_v[1]),
    .ready(rdy_v[1]), .bus_err(err_v[1])
  );

  cpu_bus_responder #(.WAIT_STATES(15)) dut15 (
    .clk(clk), .rst(rst), .enable(en_v[2]), .re(re_v[2]), .we(we_v[2]),
    .addr(addr_v[2]), .data_in(din_v[2]), .data_out(dout_v[2]),
    .ready(rdy_v[2]), .bus_err(err_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; lat counts posedges after the accepting edge until ready is seen
  // (-1 on timeout), rdy_after is ready one cycle later.
  task automatic txn(input int d, input logic r, input logic w, input logic [23:0] a,
                     input logic [7:0] di, output int lat, output logic [7:0] dout,
                     output logic err, output logic rdy_after);
    @(negedge clk);
    re_v[d] = r; we_v[d] = w; addr_v[d] = a; din_v[d] = di;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rdy_v[d]) begin
        lat = i;
        break;
      end
    end
    dout = dout_v[d];
    err  = err_v[d];
    re_v[d] = 1'b0; we_v[d] = 1'b0;
    @(posedge clk);
    #1;
    rdy_after = rdy_v[d];
  endtask

  int         lat;
  logic [7:0] dout;
  logic       err;
  logic       rdy2;
  logic       saw;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en_v = 3'b111; re_v = '0; we_v = '0; addr_v = '0; din_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", 32'(dout_v[1]), 32'h00);
    check("reset_ready", 32'(rdy_v[1]), 32'h0);
    check("reset_bus_err", 32'(err_v[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // WAIT_STATES=1: write then read back.
    txn(1, 1'b0, 1'b1, 24'h000123, 8'hA5, lat, dout, err, rdy2);
    check("ws1_wr_lat", 32'(lat), 32'd3);
    check("ws1_wr_err", 32'(err), 32'h0);
    check("ws1_wr_pulse", 32'(rdy2), 32'h0);
    txn(1, 1'b1, 1'b0, 24'h000123, 8'h00, lat, dout, err, rdy2);
    check("ws1_rd_lat", 32'(lat), 32'd3);
    check("ws1_rd_data", 32'(dout), 32'hA5);
    check("ws1_rd_err", 32'(err), 32'h0);

    // WAIT_STATES=0 and 15 latency.
    txn(0, 1'b0, 1'b1, 24'h000010, 8'h5A, lat, dout, err, rdy2);
    check("ws0_wr_lat", 32'(lat), 32'd2);
    txn(0, 1'b1, 1'b0, 24'h000010, 8'h00, lat, dout, err, rdy2);
    check("ws0_rd_lat", 32'(lat), 32'd2);
    check("ws0_rd_data", 32'(dout), 32'h5A);
    check("ws0_rd_pulse", 32'(rdy2), 32'h0);
    txn(2, 1'b0, 1'b1, 24'h000010, 8'h6B, lat, dout, err, rdy2);
    check("ws15_wr_lat", 32'(lat), 32'd17);
    txn(2, 1'b1, 1'b0, 24'h000010, 8'h00, lat, dout, err, rdy2);
    check("ws15_rd_lat", 32'(lat), 32'd17);
    check("ws15_rd_data", 32'(dout), 32'h6B);

    // Window edges: last byte hits, one past misses and must not alias RAM[0].
    txn(1, 1'b0, 1'b1, 24'h000000, 8'h11, lat, dout, err, rdy2);
    txn(1, 1'b0, 1'b1, 24'h000FFF, 8'h42, lat, dout, err, rdy2);
    check("edge_hi_wr_err", 32'(err), 32'h0);
    txn(1, 1'b1, 1'b0, 24'h000FFF, 8'h00, lat, dout, err, rdy2);
    check("edge_hi_rd_data", 32'(dout), 32'h42);
    txn(1, 1'b1, 1'b0, 24'h001000, 8'h00, lat, dout, err, rdy2);
    check("miss_rd_lat", 32'(lat), 32'd3);
    check("miss_rd_err", 32'(err), 32'h1);
    check("miss_rd_data", 32'(dout), 32'hFF);
    txn(1, 1'b1, 1'b0, 24'h000000, 8'h00, lat, dout, err, rdy2);
    check("base_rd_data", 32'(dout), 32'h11);
    txn(1, 1'b0, 1'b1, 24'h001000, 8'h77, lat, dout, err, rdy2);
    check("miss_wr_err", 32'(err), 32'h1);
    check("miss_wr_keeps_data", 32'(dout), 32'h11);
    txn(1, 1'b1, 1'b0, 24'h000000, 8'h00, lat, dout, err, rdy2);
    check("miss_wr_no_alias", 32'(dout), 32'h11);

    // re and we together: flagged, open bus, RAM untouched.
    txn(1, 1'b0, 1'b1, 24'h000020, 8'h5C, lat, dout, err, rdy2);
    txn(1, 1'b1, 1'b1, 24'h000020, 8'h99, lat, dout, err, rdy2);
    check("illegal_err", 32'(err), 32'h1);
    check("illegal_data", 32'(dout), 32'hFF);
    txn(1, 1'b1, 1'b0, 24'h000020, 8'h00, lat, dout, err, rdy2);
    check("illegal_ram_kept", 32'(dout), 32'h5C);

    // Reset during WAIT of a write aborts it.
    txn(1, 1'b0, 1'b1, 24'h000030, 8'hC3, lat, dout, err, rdy2);
    txn(1, 1'b1, 1'b0, 24'h000030, 8'h00, lat, dout, err, rdy2);
    check("pre_rst_data", 32'(dout), 32'hC3);
    @(negedge clk);
    we_v[1] = 1'b1; addr_v[1] = 24'h000030; din_v[1] = 8'h3C;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_data", 32'(dout_v[1]), 32'h00);
    check("rst_mid_ready", 32'(rdy_v[1]), 32'h0);
    check("rst_mid_err", 32'(err_v[1]), 32'h0);
    @(negedge clk);
    we_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rdy_v[1]) saw = 1'b1;
    end
    check("rst_no_ready", 32'(saw), 32'h0);
    txn(1, 1'b1, 1'b0, 24'h000030, 8'h00, lat, dout, err, rdy2);
    check("rst_ram_kept", 32'(dout), 32'hC3);

    // enable low holds off a pending read; address change mid-WAIT is ignored.
    @(negedge clk);
    en_v[1] = 1'b0; re_v[1] = 1'b1; addr_v[1] = 24'h000123;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rdy_v[1]) saw = 1'b1;
    end
    check("en_low_no_ready", 32'(saw), 32'h0);
    @(negedge clk);
    en_v[1] = 1'b1;
    @(posedge clk);
    #1;
    addr_v[1] = 24'h000030;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rdy_v[1]) begin
        lat = i;
        break;
      end
    end
    re_v[1] = 1'b0;
    check("en_high_lat", 32'(lat), 32'd3);
    check("en_high_latched_addr", 32'(dout_v[1]), 32'hA5);
    check("en_high_err", 32'(err_v[1]), 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
